// File: rtl/sccb_pkg.sv
// sccb_pkg: shared types and constants for the SCCB target.
//   state_t    : protocol phase of the target FSM
//   ACK_BIT    : index of the ack / don't-care slot within a phase
//   BYTE_BITS  : data bits per phase, MSB first
//   DEF_DEV_ID : default 8-bit write address (bit0 ignored)
package sccb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ID,
      SUB,
      WDATA,
      RDATA,
      IGNORE
   } state_t;

   localparam int ACK_BIT   = 8;
   localparam int BYTE_BITS = 8;

   localparam logic [7:0] DEF_DEV_ID = 8'h42;

endpackage

// File: rtl/sccb_target_if.sv
// sccb_target_if: SCCB line pins plus the local consumer port of the target.
//   sio_c, sio_d_i : SCCB clock and data pad input (driven by master side)
//   sio_d_oe       : 1 = target pulls SIO_D low (open-drain)
//   busy           : START seen and no STOP yet
//   wr_pulse       : single-cycle strobe; wr_addr/wr_data are valid only while
//                    it is high, there is no back-pressure (consumer must accept)
//   loc_addr       : local read address, loc_rdata is its combinational value
//   state          : current FSM phase, exported for observation
interface sccb_target_if;
   import sccb_pkg::*;

   logic       sio_c;
   logic       sio_d_i;
   logic       sio_d_oe;
   logic       busy;
   logic       wr_pulse;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] loc_addr;
   logic [7:0] loc_rdata;
   state_t     state;

   modport slave (
      input  sio_c, sio_d_i, loc_addr,
      output sio_d_oe, busy, wr_pulse, wr_addr, wr_data, loc_rdata, state
   );

   modport master (
      output sio_c, sio_d_i, loc_addr,
      input  sio_d_oe, busy, wr_pulse, wr_addr, wr_data, loc_rdata, state
   );

endinterface

// File: rtl/sccb_line_sync.sv
// sccb_line_sync: synchronizes SIO_C/SIO_D into the PCLK domain and decodes
// line events from the synchronized values.
//   clk, rst_n     : PCLK and asynchronous active-low reset
//   sio_c, sio_d   : raw pad values
//   rise_c, fall_c : single-cycle SIO_C edge flags
//   start, stop    : single-cycle START / STOP flags
//   d_smp          : synchronized SIO_D
module sccb_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sio_c,
   input  logic sio_d,
   output logic rise_c,
   output logic fall_c,
   output logic start,
   output logic stop,
   output logic d_smp
);

   logic [SYNC_STAGES-1:0] c_sync;
   logic [SYNC_STAGES-1:0] d_sync;
   logic                   c_hist;
   logic                   d_hist;
   logic                   c_smp;

   // Reset to the idle-bus level (both lines high) so leaving reset on an
   // idle bus produces no spurious edge or START/STOP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_sync <= '1;
         d_sync <= '1;
         c_hist <= 1'b1;
         d_hist <= 1'b1;
      end else begin
         c_sync <= {c_sync[SYNC_STAGES-2:0], sio_c};
         d_sync <= {d_sync[SYNC_STAGES-2:0], sio_d};
         c_hist <= c_sync[SYNC_STAGES-1];
         d_hist <= d_sync[SYNC_STAGES-1];
      end
   end

   assign c_smp  = c_sync[SYNC_STAGES-1];
   assign d_smp  = d_sync[SYNC_STAGES-1];
   assign rise_c = c_smp & ~c_hist;
   assign fall_c = ~c_smp & c_hist;
   // SIO_D may only move while SIO_C is high for START/STOP, so both the
   // current and previous clock samples must be high.
   assign start  = c_smp & c_hist & d_hist & ~d_smp;
   assign stop   = c_smp & c_hist & ~d_hist & d_smp;

endmodule

// File: rtl/sccb_target.sv
// sccb_target: SCCB responder with an internal register file.
//   PCLK, PRESETN : system clock, asynchronous active-low reset
//   bus           : sccb_target_if.slave (SIO lines, write-commit strobe,
//                   local read port, FSM phase)
// Decodes 3-phase writes (ID, sub-address, data) and 2-phase reads (ID, data).
module sccb_target import sccb_pkg::*; #(
   parameter logic [7:0] DEV_ID      = DEF_DEV_ID,
   parameter int         NUM_REGS    = 32,
   parameter int         SYNC_STAGES = 2
) (
   input  logic         PCLK,
   input  logic         PRESETN,
   sccb_target_if.slave bus
);

   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic       rise_c, fall_c, start, stop, d_smp;
   state_t     state, state_nxt;
   logic [3:0] bit_cnt;
   logic       ack_rise;   // rise_c of the ack slot already seen
   logic       ack_en;     // this phase's byte is to be acked
   logic       rw;
   logic [6:0] shreg;
   logic [7:0] sub_addr;
   logic [7:0] rd_shift;
   logic       sio_d_oe, busy, wr_pulse;
   logic [7:0] wr_addr, wr_data;
   logic [7:0] regs [NUM_REGS];

   logic [7:0] byte_in;
   logic       active, byte_done, slot_open, slot_close, id_match;
   logic [7:0] rd_byte;

   sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (PCLK),
      .rst_n  (PRESETN),
      .sio_c  (bus.sio_c),
      .sio_d  (bus.sio_d_i),
      .rise_c (rise_c),
      .fall_c (fall_c),
      .start  (start),
      .stop   (stop),
      .d_smp  (d_smp)
   );

   assign byte_in    = {shreg, d_smp};
   assign active     = state inside {ID, SUB, WDATA, RDATA};
   assign byte_done  = active & rise_c & (bit_cnt == 4'(BYTE_BITS - 1));
   // Ack slot spans from the fall after bit 7 to the fall after bit 8.
   assign slot_open  = active & fall_c & (bit_cnt == 4'(ACK_BIT)) & ~ack_rise;
   assign slot_close = active & fall_c & (bit_cnt == 4'(ACK_BIT)) & ack_rise;
   assign id_match   = (byte_in[7:1] == DEV_ID[7:1]);
   assign rd_byte    = (32'(sub_addr) < NUM_REGS) ? regs[sub_addr[IDX_W-1:0]] : 8'hFF;

   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = ID;
      end else if (stop) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            ID: begin
               if (byte_done && !id_match) state_nxt = IGNORE;
               else if (slot_close)        state_nxt = rw ? RDATA : SUB;
            end
            SUB:   if (slot_close) state_nxt = WDATA;
            WDATA: if (slot_close) state_nxt = IGNORE;
            RDATA: if (slot_close) state_nxt = IGNORE;
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) state <= IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         bit_cnt  <= '0;
         ack_rise <= 1'b0;
         ack_en   <= 1'b0;
         rw       <= 1'b0;
         shreg    <= '0;
         sub_addr <= '0;
         rd_shift <= '0;
         sio_d_oe <= 1'b0;
         busy     <= 1'b0;
         wr_pulse <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         wr_pulse <= 1'b0;
         // The array is written as the strobe retires, so a same-cycle local
         // read still returns the previous contents.
         if (wr_pulse && (32'(wr_addr) < NUM_REGS)) regs[wr_addr[IDX_W-1:0]] <= wr_data;

         if (start || stop) begin
            bit_cnt  <= '0;
            ack_rise <= 1'b0;
            ack_en   <= 1'b0;
            sio_d_oe <= 1'b0;
            busy     <= start;
         end else if (active) begin
            if (rise_c) begin
               if (bit_cnt < 4'(ACK_BIT)) begin
                  shreg   <= byte_in[6:0];
                  bit_cnt <= bit_cnt + 4'd1;
               end else begin
                  ack_rise <= 1'b1;
               end
            end

            if (byte_done) begin
               case (state)
                  ID: begin
                     if (id_match) begin
                        rw     <= byte_in[0];
                        ack_en <= 1'b1;
                     end
                  end
                  SUB: begin
                     sub_addr <= byte_in;
                     ack_en   <= 1'b1;
                  end
                  WDATA: begin
                     wr_pulse <= 1'b1;
                     wr_addr  <= sub_addr;
                     wr_data  <= byte_in;
                     ack_en   <= 1'b1;
                  end
                  default: ;
               endcase
            end

            if (slot_open) begin
               sio_d_oe <= ack_en;
            end else if (slot_close) begin
               bit_cnt  <= '0;
               ack_rise <= 1'b0;
               ack_en   <= 1'b0;
               sio_d_oe <= 1'b0;
               // Read data MSB goes out on the fall that ends the ID ack slot.
               if (state == ID && rw) begin
                  rd_shift <= rd_byte;
                  sio_d_oe <= ~rd_byte[7];
               end
            end else if (fall_c && state == RDATA && bit_cnt != 4'd0) begin
               sio_d_oe <= ~rd_shift[3'(4'd7 - bit_cnt)];
            end
         end
      end
   end

   assign bus.sio_d_oe  = sio_d_oe;
   assign bus.busy      = busy;
   assign bus.wr_pulse  = wr_pulse;
   assign bus.wr_addr   = wr_addr;
   assign bus.wr_data   = wr_data;
   assign bus.state     = state;
   assign bus.loc_rdata = (32'(bus.loc_addr) < NUM_REGS) ? regs[bus.loc_addr[IDX_W-1:0]] : 8'hFF;

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: directed bench for sccb_target acting as an SCCB master
// with an open-drain SIO_D model.
module tb_sccb_target;
   import sccb_pkg::*;

   localparam int Q = 10;   // PCLK cycles per quarter SIO_C period

   // ---------------- clock / reset ----------------
   logic pclk    = 1'b0;
   logic presetn = 1'b0;
   always #5 pclk = ~pclk;

   logic       m_c      = 1'b1;
   logic       m_d      = 1'b1;
   logic [7:0] loc_addr = 8'h00;

   sccb_target_if bus ();

   assign bus.sio_c    = m_c;
   assign bus.sio_d_i  = m_d & ~bus.sio_d_oe;
   assign bus.loc_addr = loc_addr;

   sccb_target #(.DEV_ID(8'h42), .NUM_REGS(32), .SYNC_STAGES(2)) dut (
      .PCLK    (pclk),
      .PRESETN (presetn),
      .bus     (bus)
   );

   // ---------------- checking ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];
   int          oe_cycles = 0;
   logic        pulse_d   = 1'b0;
   logic [7:0]  rd_at_pulse    = 8'h00;
   logic [7:0]  rd_after_pulse = 8'h00;

   always @(negedge pclk) begin
      if (pulse_d) rd_after_pulse = bus.loc_rdata;
      pulse_d = bus.wr_pulse;
      if (bus.wr_pulse) begin
         got_q.push_back({bus.wr_addr, bus.wr_data});
         rd_at_pulse = bus.loc_rdata;
      end
      if (bus.sio_d_oe) oe_cycles++;
   end

   task automatic check_commits(input string tag);
      check_eq({tag, "_ncommit"}, 32'(got_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && got_q.size() > 0)
         check_eq({tag, "_commit"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      exp_q.delete();
      got_q.delete();
   endtask

   // ---------------- master driver ----------------
   task automatic wait_q();
      repeat (Q) @(posedge pclk);
   endtask

   task automatic m_start();
      m_d = 1'b1; wait_q();
      m_c = 1'b1; wait_q();
      m_d = 1'b0; wait_q();
      m_c = 1'b0; wait_q();
   endtask

   task automatic m_stop();
      m_c = 1'b0; m_d = 1'b0; wait_q();
      m_c = 1'b1; wait_q();
      m_d = 1'b1; wait_q();
   endtask

   task automatic m_bit(input logic b, output logic line);
      m_d = b; wait_q();
      m_c = 1'b1; wait_q();
      @(negedge pclk);
      line = bus.sio_d_i;
      wait_q();
      m_c = 1'b0; wait_q();
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic l;
      for (int i = 7; i >= 0; i--) m_bit(b[i], l);
      m_bit(1'b1, l);
      ack = ~l;
   endtask

   task automatic recv_byte(input logic nack, output logic [7:0] v);
      logic l;
      for (int i = 7; i >= 0; i--) begin
         m_bit(1'b1, l);
         v[i] = l;
      end
      m_bit(nack, l);
   endtask

   task automatic write3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         output logic [2:0] acks);
      m_start();
      send_byte(a, acks[2]);
      send_byte(b, acks[1]);
      send_byte(c, acks[0]);
      m_stop();
   endtask

   task automatic read_at(input logic [7:0] sub, output logic [2:0] acks, output logic [7:0] v);
      m_start();
      send_byte(8'h42, acks[2]);
      send_byte(sub, acks[1]);
      m_stop();
      m_start();
      send_byte(8'h43, acks[0]);
      recv_byte(1'b1, v);
      m_stop();
   endtask

   task automatic check_loc(input string tag, input logic [7:0] a, input logic [7:0] exp);
      loc_addr = a;
      @(negedge pclk);
      check_eq(tag, 32'(bus.loc_rdata), 32'(exp));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [2:0] acks;
      logic [7:0] v;
      logic       l;
      int         oe_before;

      repeat (5) @(posedge pclk);
      @(negedge pclk);
      check_eq("rst_oe",     32'(bus.sio_d_oe), 32'(0));
      check_eq("rst_busy",   32'(bus.busy),     32'(0));
      check_eq("rst_pulse",  32'(bus.wr_pulse), 32'(0));
      check_eq("rst_waddr",  32'(bus.wr_addr),  32'(0));
      check_eq("rst_wdata",  32'(bus.wr_data),  32'(0));
      check_eq("rst_state",  32'(bus.state),    32'(IDLE));
      presetn = 1'b1;
      wait_q();
      check_loc("rst_reg12", 8'h12, 8'h00);

      // Plain write 0x12 <= 0x80
      loc_addr = 8'h12;
      exp_q.push_back(16'h1280);
      m_start();
      check_eq("t1_busy_on", 32'(bus.busy), 32'(1));
      send_byte(8'h42, acks[2]);
      send_byte(8'h12, acks[1]);
      send_byte(8'h80, acks[0]);
      m_stop();
      check_eq("t1_acks", 32'(acks), 32'(3'b111));
      check_commits("t1");
      check_eq("t1_rd_old", 32'(rd_at_pulse),    32'(8'h00));
      check_eq("t1_rd_new", 32'(rd_after_pulse), 32'(8'h80));
      check_loc("t1_loc12", 8'h12, 8'h80);
      check_eq("t1_busy_off", 32'(bus.busy), 32'(0));

      // Read back 0x12
      read_at(8'h12, acks, v);
      check_eq("t2_acks", 32'(acks), 32'(3'b111));
      check_eq("t2_rdata", 32'(v), 32'(8'h80));
      check_commits("t2");
      check_eq("t2_oe_idle", 32'(bus.sio_d_oe), 32'(0));

      // Foreign device ID: never drive, no commit
      oe_before = oe_cycles;
      write3(8'h60, 8'h12, 8'h34, acks);
      check_eq("t3_acks", 32'(acks), 32'(3'b000));
      check_eq("t3_oe_cycles", 32'(oe_cycles - oe_before), 32'(0));
      check_commits("t3");
      check_loc("t3_loc12", 8'h12, 8'h80);

      // Out-of-range sub-address
      exp_q.push_back(16'h4055);
      write3(8'h42, 8'h40, 8'h55, acks);
      check_eq("t4_acks", 32'(acks), 32'(3'b111));
      check_commits("t4");
      read_at(8'h40, acks, v);
      check_eq("t4_rd_acks", 32'(acks), 32'(3'b111));
      check_eq("t4_rdata", 32'(v), 32'(8'hFF));
      check_loc("t4_loc40", 8'h40, 8'hFF);
      check_loc("t4_loc1f", 8'h1F, 8'h00);

      // STOP mid data byte aborts
      m_start();
      send_byte(8'h42, acks[2]);
      send_byte(8'h05, acks[1]);
      m_bit(1'b1, l); m_bit(1'b0, l); m_bit(1'b1, l); m_bit(1'b0, l);
      m_stop();
      check_commits("t5");
      check_loc("t5_loc05", 8'h05, 8'h00);
      check_eq("t5_state", 32'(bus.state), 32'(IDLE));

      // Repeated START mid sub-address restarts the ID phase
      exp_q.push_back(16'h073C);
      m_start();
      send_byte(8'h42, acks[2]);
      m_bit(1'b0, l); m_bit(1'b0, l); m_bit(1'b1, l); m_bit(1'b1, l);
      m_start();
      check_eq("t5_rs_busy",  32'(bus.busy),  32'(1));
      check_eq("t5_rs_state", 32'(bus.state), 32'(ID));
      send_byte(8'h42, acks[2]);
      send_byte(8'h07, acks[1]);
      send_byte(8'h3C, acks[0]);
      m_stop();
      check_eq("t5_rs_acks", 32'(acks), 32'(3'b111));
      check_commits("t5_rs");
      check_loc("t5_loc07", 8'h07, 8'h3C);

      // Reset pulse while acking the ID byte
      m_start();
      for (int i = 7; i >= 0; i--) m_bit(1'(8'h42 >> i), l);
      check_eq("t6_ack_drive", 32'(bus.sio_d_oe), 32'(1));
      @(negedge pclk);
      presetn = 1'b0;
      #1;
      check_eq("t6_rst_oe",   32'(bus.sio_d_oe), 32'(0));
      check_eq("t6_rst_busy", 32'(bus.busy),     32'(0));
      check_loc("t6_rst_reg12", 8'h12, 8'h00);
      m_c = 1'b1;
      m_d = 1'b1;
      wait_q();
      presetn = 1'b1;
      wait_q();
      exp_q.push_back(16'h01A5);
      write3(8'h42, 8'h01, 8'hA5, acks);
      check_eq("t6_acks", 32'(acks), 32'(3'b111));
      check_commits("t6");
      check_loc("t6_loc01", 8'h01, 8'hA5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sccb_target.md
Name: sccb_target

Overview:
- SCCB responder (camera-side target) that answers the SCCB master already in the design.
- Oversamples SIO_C/SIO_D on PCLK, decodes 3-phase write and 2-phase read transactions, and holds an internal register file.
- Used as a loop-back camera model for on-chip self-test and as the bench partner for the master.
- Exposes a local read port and a write-commit strobe so other logic can consume configured values.

Parameters:
- DEV_ID, 8'h42: 8-bit write address; bit0 ignored, read address = DEV_ID|1.
- NUM_REGS, 32: register file depth (must be ≤ 256); index = sub-address.
- SYNC_STAGES, 2: synchronizer flops on SIO_C/SIO_D (≥ 2).

Ports:
- PCLK  in  1  system clock; must be ≥ 20× SIO_C frequency.
- PRESETN  in  1  asynchronous active-low reset.
- SIO_C  in  1  SCCB clock from master.
- sio_d_i  in  1  SCCB data pad input.
- sio_d_oe  out  1  1 = pull SIO_D low (open-drain); 0 = release.
- busy  out  1  high from a detected START to a detected STOP.
- wr_pulse  out  1  one-cycle strobe when a write commits.
- wr_addr  out  8  sub-address of the committed write.
- wr_data  out  8  data of the committed write.
- loc_addr  in  8  local read address.
- loc_rdata  out  8  combinational reg[loc_addr]; 8'hFF if loc_addr ≥ NUM_REGS.

Behaviour:
- Reset: sio_d_oe=0, busy=0, wr_pulse=0, wr_addr=0, wr_data=0, all regs=0, state=IDLE, sub_addr=0, bit_cnt=0.
- Line sampling
  - SIO_C/SIO_D pass through SYNC_STAGES flops plus one history flop.
  - Events are decoded from the synchronized values:
    - rise_c / fall_c: edges on SIO_C.
    - START: SIO_D 1→0 while SIO_C=1.
    - STOP: SIO_D 0→1 while SIO_C=1.
  - Event latency is SYNC_STAGES+1 PCLK cycles after the pin change.
- Framing
  - bit_cnt 0..8 per phase; MSB first.
  - Bits 0..7 are sampled on rise_c; bit 8 is the ack/don't-care slot.
  - bit_cnt increments on each rise_c and clears on fall_c following bit 8.
- States:
  - IDLE → ID on START.
  - ID: shift 8 bits. On the 8th rise_c:
    - if byte[7:1]==DEV_ID[7:1]: latch rw=byte[0], drive ack;
    - else go to IGNORE (no ack).
    - After the ack slot: rw=0 → SUB, rw=1 → RDATA.
  - SUB: shift 8 bits, latch sub_addr, ack, then → WDATA.
  - WDATA: shift 8 bits, ack, then → IGNORE.
    - Commit in the cycle after the 8th rise_c: wr_pulse=1 with wr_addr/wr_data.
    - reg[sub_addr] is updated only if sub_addr < NUM_REGS; out-of-range writes are still acked and still pulse.
  - RDATA: shift out reg[sub_addr] (8'hFF if out of range), using the sub_addr latched by the most recent write phase.
    - Master's 9th bit is ignored; after it → IGNORE.
  - IGNORE: sio_d_oe=0, wait.
- Ack drive: sio_d_oe=1 from the fall_c after bit 7 until the fall_c after bit 8.
- Read drive
  - Data bit n is placed on the fall_c preceding its rise_c: sio_d_oe = ~bit.
  - The first bit is placed on the fall_c that ends the ID ack slot.
  - sio_d_oe is released on the fall_c after bit 7.
- Global overrides, from any state:
  - START → ID (repeated start) and release SIO_D.
  - STOP → IDLE and release SIO_D.
  - STOP mid-byte aborts with no commit.
- busy: set on START, cleared on STOP; a repeated START keeps it high.
- Simultaneous wr_pulse and a loc_addr read of the same address: loc_rdata returns the old value that cycle and the new value next cycle.
- PRESETN low mid-transaction: immediate release of SIO_D and full reset, including the register file.

Decomposition:
- Package sccb_pkg holds:
  - state enum {IDLE, ID, SUB, WDATA, RDATA, IGNORE};
  - ACK_BIT=8 and BYTE_BITS=8;
  - the default DEV_ID 8'h42.
- Natural sub-module sccb_line_sync: synchronizers plus edge/START/STOP detection, outputting rise_c, fall_c, start, stop, and the sampled SIO_D.

Test Plan:
- Write 0x42, 0x12, 0x80, STOP → three acks (SIO_D low in each slot), one wr_pulse with wr_addr=0x12 and wr_data=0x80, loc_addr=0x12 reads 0x80, busy low after STOP.
- After the above: write phase 0x42, 0x12, STOP; then read phase 0x43 → target shifts out 0x80, master NA, STOP; no wr_pulse during the read.
- ID 0x60 (mismatch) followed by 2 bytes → SIO_D never driven, no wr_pulse, regs unchanged.
- Write 0x42, 0x40 (≥ NUM_REGS), 0x55 → acked, wr_pulse with addr=0x40; then read 0x43 returns 0xFF and loc_addr=0x40 gives 0xFF.
- STOP after 4 bits of the data byte in a write to 0x05 → no commit, reg[0x05]=0, next transaction decodes normally; repeated START mid-SUB restarts the ID phase.
- PRESETN pulsed low while acking → sio_d_oe=0 within the same cycle; after release the 0x42, 0x01, 0xA5 write succeeds.
